unified_mem_arbiter: RTL and testbench

//  Shares one single-ported instruction/data memory between two requesters.
//  - Instruction-fetch requester: instruction-cache miss/uncached path.
//  - Data requester: load/store unit.

---
 rtl/unified_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, fixed-latency synchronous memory between an
// instruction-fetch requester and a load/store requester. Data has priority;
// a saturating streak counter guarantees that fetches make progress.
module unified_mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  we_q, we_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  mem_en_q, mem_en_d;
    logic [STRB_W-1:0]     mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic                  if_valid_q, if_valid_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
    logic                  d_valid_q, d_valid_d;
    logic                  grant_d, grant_i;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_valid_d   = 1'b0;
        grant_d     = d_req && !(if_req && streak_q == STREAK_MAX);
        grant_i     = if_req && !grant_d;

        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    owner_d     = OWN_D;
                    we_d        = d_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we ? d_wstrb : '0;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_we ? d_wdata : '0;
                    // A data grant with a fetch pending implies streak < max, so +1 cannot overflow.
                    streak_d    = if_req ? streak_q + 1'b1 : '0;
                    state_d     = S_ACCESS;
                end else if (grant_i) begin
                    owner_d    = OWN_IF;
                    we_d       = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = if_addr;
                    streak_d   = '0;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    d_valid_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        d_rdata_d = mem_rdata;
                        d_valid_d = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: asynchronous active-low reset; all state uses non-blocking assignment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: a 1-cycle-latency instance with a byte-strobed memory model,
// plus a 3-cycle-latency instance that presents garbage outside its read slot.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Latency-1 instance
    logic        if_req, if_valid, d_req, d_we, d_valid, mem_en, busy;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  d_wstrb, mem_we;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    logic [31:0] mem [0:255];
    logic        rd_v;
    logic [31:0] rd_d;
    always @(posedge clk) begin
        rd_v <= mem_en && (mem_we == 4'b0);
        rd_d <= mem[mem_addr[9:2]];
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = rd_v ? rd_d : 32'hBAD0_BAD0;

    // Latency-3 instance
    logic        if_valid3, d_req3, d_valid3, mem_en3, busy3;
    logic [31:0] if_rdata3, d_addr3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [3:0]  mem_we3;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_DATA_STREAK(4)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr(32'h0), .if_rdata(if_rdata3), .if_valid(if_valid3),
        .d_req(d_req3), .d_we(1'b0), .d_wstrb(4'b0), .d_addr(d_addr3), .d_wdata(32'h0),
        .d_rdata(d_rdata3), .d_valid(d_valid3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    logic [2:0]  s_v;
    logic [31:0] s_a [0:2];
    logic [15:0] cyc16 = 16'h0;
    always @(posedge clk) begin
        cyc16  <= cyc16 + 16'h1;
        s_v    <= {s_v[1:0], mem_en3};
        s_a[0] <= mem_addr3;
        s_a[1] <= s_a[0];
        s_a[2] <= s_a[1];
    end
    assign mem_rdata3 = s_v[2] ? (s_a[2] ^ 32'h5555_0000) : {16'hBAD0, cyc16};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_wstrb;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_mem_en;
        logic [3:0]  e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_if_valid;
        logic [31:0] e_if_rdata;
        logic        e_d_valid;
        logic [31:0] e_d_rdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs [19];

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".mem_en"},    {31'h0, mem_en},   {31'h0, v.e_mem_en});
        check({tag, ".mem_we"},    {28'h0, mem_we},   {28'h0, v.e_mem_we});
        check({tag, ".mem_addr"},  mem_addr,          v.e_mem_addr);
        check({tag, ".mem_wdata"}, mem_wdata,         v.e_mem_wdata);
        check({tag, ".if_valid"},  {31'h0, if_valid}, {31'h0, v.e_if_valid});
        check({tag, ".if_rdata"},  if_rdata,          v.e_if_rdata);
        check({tag, ".d_valid"},   {31'h0, d_valid},  {31'h0, v.e_d_valid});
        check({tag, ".d_rdata"},   d_rdata,           v.e_d_rdata);
        check({tag, ".busy"},      {31'h0, busy},     {31'h0, v.e_busy});
    endtask

    task automatic drive(input vec_t v);
        if_req  = v.if_req;  if_addr = v.if_addr;
        d_req   = v.d_req;   d_we    = v.d_we;   d_wstrb = v.d_wstrb;
        d_addr  = v.d_addr;  d_wdata = v.d_wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  zero;
        string order;
        int    ngr, cyc, n;
        logic [7:0] g;

        //          ifq if_addr       dq we strb  d_addr        d_wdata        en we    mem_addr      mem_wdata      iv if_rdata       dv d_rdata        busy
        // Fetch, latency 1
        vecs[0]  = '{1, 32'h40,       0, 0, 4'h0, 32'h0,        32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0,         0, 32'h0,         0};
        vecs[1]  = '{1, 32'h40,       0, 0, 4'h0, 32'h0,        32'h0,         1, 4'h0, 32'h40,       32'h0,         0, 32'h0,         0, 32'h0,         1};
        vecs[2]  = '{1, 32'h40,       0, 0, 4'h0, 32'h0,        32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0,         0, 32'h0,         1};
        vecs[3]  = '{1, 32'h40,       0, 0, 4'h0, 32'h0,        32'h0,         0, 4'h0, 32'h0,        32'h0,         1, 32'h0010_0093, 0, 32'h0,         1};
        vecs[4]  = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 0, 32'h0,         0};
        // Store with partial strobes: d_rdata must stay untouched
        vecs[5]  = '{0, 32'h0,        1, 1, 4'h3, 32'h1000,     32'hDEAD_BEEF, 0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 0, 32'h0,         0};
        vecs[6]  = '{0, 32'h0,        1, 1, 4'h3, 32'h1000,     32'hDEAD_BEEF, 1, 4'h3, 32'h1000,     32'hDEAD_BEEF, 0, 32'h0010_0093, 0, 32'h0,         1};
        vecs[7]  = '{0, 32'h0,        1, 1, 4'h3, 32'h1000,     32'hDEAD_BEEF, 0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 1, 32'h0,         1};
        vecs[8]  = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 0, 32'h0,         0};
        // Load back the stored word (only the two strobed bytes written)
        vecs[9]  = '{0, 32'h0,        1, 0, 4'h0, 32'h1000,     32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 0, 32'h0,         0};
        vecs[10] = '{0, 32'h0,        1, 0, 4'h0, 32'h1000,     32'h0,         1, 4'h0, 32'h1000,     32'h0,         0, 32'h0010_0093, 0, 32'h0,         1};
        vecs[11] = '{0, 32'h0,        1, 0, 4'h0, 32'h1000,     32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 0, 32'h0,         1};
        vecs[12] = '{0, 32'h0,        1, 0, 4'h0, 32'h1000,     32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 1, 32'h0000_BEEF, 1};
        // New load raised right after d_valid: granted from that IDLE cycle, once
        vecs[13] = '{0, 32'h0,        1, 0, 4'h0, 32'h2004,     32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 0, 32'h0000_BEEF, 0};
        vecs[14] = '{0, 32'h0,        1, 0, 4'h0, 32'h2004,     32'h0,         1, 4'h0, 32'h2004,     32'h0,         0, 32'h0010_0093, 0, 32'h0000_BEEF, 1};
        vecs[15] = '{0, 32'h0,        1, 0, 4'h0, 32'h2004,     32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 0, 32'h0000_BEEF, 1};
        vecs[16] = '{0, 32'h0,        1, 0, 4'h0, 32'h2004,     32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 1, 32'h1234_5678, 1};
        vecs[17] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 0, 32'h1234_5678, 0};
        vecs[18] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,         0, 4'h0, 32'h0,        32'h0,         0, 32'h0010_0093, 0, 32'h1234_5678, 0};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h0010_0093;
        mem[8'h01] = 32'h1234_5678;
        zero = '{0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0};
        s_v     = 3'b0;
        reset   = 1'b0;
        d_req3  = 1'b0;
        d_addr3 = 32'h0;
        drive(zero);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", zero);
        reset = 1'b1;

        // Table: fetch, store, load-back, back-to-back load
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Both requesters held: data-priority with streak limit
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_wstrb = 4'h0; d_addr = 32'h80; d_wdata = 32'h0;
        order = "DDDDIDDDDI";
        ngr = 0;
        cyc = 0;
        while (ngr < 10 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (mem_en) begin
                g = (mem_addr == 32'h40) ? "I" : "D";
                check($sformatf("grant%0d", ngr), {24'h0, g}, {24'h0, order[ngr]});
                ngr++;
            end
        end
        if (ngr < 10) check("grant_timeout", ngr, 10);
        while (!if_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("streak_last_ivalid", {31'h0, if_valid}, 32'h1);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("streak_idle_busy", {31'h0, busy}, 32'h0);

        // Latency-3 load: only the slot at c4 is captured
        @(posedge clk); #1;
        d_req3 = 1'b1; d_addr3 = 32'h3000;
        @(negedge clk);
        check("l3_c0_mem_en", {31'h0, mem_en3}, 32'h0);
        @(negedge clk);
        check("l3_c1_mem_en", {31'h0, mem_en3}, 32'h1);
        check("l3_c1_mem_addr", mem_addr3, 32'h3000);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("l3_c%0d_mem_en", c), {31'h0, mem_en3}, 32'h0);
            check($sformatf("l3_c%0d_d_valid", c), {31'h0, d_valid3}, 32'h0);
            check($sformatf("l3_c%0d_d_rdata", c), d_rdata3, 32'h0);
        end
        @(negedge clk);
        check("l3_c5_d_valid", {31'h0, d_valid3}, 32'h1);
        check("l3_c5_d_rdata", d_rdata3, 32'h5555_3000);
        @(posedge clk); #1;
        d_req3 = 1'b0;
        @(negedge clk);
        check("l3_c6_busy", {31'h0, busy3}, 32'h0);
        check("l3_c6_d_valid", {31'h0, d_valid3}, 32'h0);

        // Reset during WAIT of a fetch, request still held afterwards
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_all("rst_wait", zero);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rst_hold%0d_if_valid", c), {31'h0, if_valid}, 32'h0);
        end
        reset = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (if_valid) break;
        end
        check("rst_restart_latency", n, 3);
        check("rst_restart_if_rdata", if_rdata, 32'h0010_0093);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("rst_restart_idle", {31'h0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
